z80_bus_arbiter: RTL and testbench

Arbitrates ownership of the shared Z80 bus between the CPU (master 0) and secondary masters such as DMA engines (masters 1..MASTER_QTY-1). It drives the master-select index into the downstream master/slave bus multiplexer and runs the Z80 BUSREQ/BUSACK handshake with the CPU. The CPU owns the bus by default. Secondary masters win in round-robin order, with a guaranteed idle turnaround cycle between owners.

---
 rtl/z80_bus_arbiter_if.sv | 30 +++
 rtl/z80_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/z80_bus_arbiter_if.sv
// z80_bus_arbiter_if
//   Bundles the bus-arbitration signals of z80_bus_arbiter.
//   slave modport  : the arbiter's view (requests and BUSACK in; grant, select,
//                    BUSREQ, status out).
//   master modport : the requester/CPU side (drives req and busackn).
//   Signals:
//     req[MASTER_QTY]  per-master level request (bit 0 = CPU, ignored)
//     grant[MASTER_QTY] one-hot or all-zero ownership
//     msel[MSEL_W]     master-select index for the bus mux
//     busreqn          Z80 BUSREQ, active low
//     busackn          Z80 BUSACK, active low, synchronous to clk
//     busy             high whenever the CPU is not the settled owner
//     timeout          one-cycle pulse on forced revocation
interface z80_bus_arbiter_if #(
  parameter int MASTER_QTY = 3,
  parameter int MSEL_W     = ($clog2(MASTER_QTY) > 1) ? $clog2(MASTER_QTY) : 1
);
  logic [MASTER_QTY-1:0] req;
  logic [MASTER_QTY-1:0] grant;
  logic [MSEL_W-1:0]     msel;
  logic                  busreqn;
  logic                  busackn;
  logic                  busy;
  logic                  timeout;

  modport slave  (input  req, busackn,
                  output grant, msel, busreqn, busy, timeout);
  modport master (output req, busackn,
                  input  grant, msel, busreqn, busy, timeout);
endinterface

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter
//   Hands the shared Z80 bus between the CPU (master 0, default owner) and
//   secondary masters 1..MASTER_QTY-1 using the BUSREQ/BUSACK handshake.
//   Secondary masters are served round-robin with a one-cycle idle turnaround
//   (grant=0, msel held) between consecutive owners. All outputs are registered.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    z80_bus_arbiter_if.slave (req, busackn in; grant, msel, busreqn,
//            busy, timeout out)
//   Optional feature: define Z80_ARB_TIMEOUT_EN to limit a grant to
//   TIMEOUT_CYCLES cycles; the revoked master is masked until it drops req.
module z80_bus_arbiter #(
  parameter int MASTER_QTY     = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MSEL_W         = ($clog2(MASTER_QTY) > 1) ? $clog2(MASTER_QTY) : 1
) (
  input  logic              clk,
  input  logic              reset,
  z80_bus_arbiter_if.slave  bus
);
  localparam int N = MASTER_QTY;
  localparam logic [N-1:0] CPU_BIT = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {CPU_OWN, REQ_CPU, GRANT, TURN, RELEASE} state_t;

  state_t            state_q;
  logic [N-1:0]      grant_q;
  logic [MSEL_W-1:0] msel_q;
  logic [MSEL_W-1:0] last_q;
  logic              busreqn_q;
  logic              busy_q;

  logic [N-1:0]      mask;
  logic              tmo_hit;

`ifdef Z80_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]  cnt_q;
  logic [N-1:0]      mask_q;
  logic              timeout_q;

  assign tmo_hit = (state_q == GRANT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mask    = mask_q;

  // GRANT is never re-entered directly (always via TURN/REQ_CPU), so clearing
  // the count outside GRANT makes the first GRANT cycle count 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == GRANT) ? cnt_q + 1'b1 : '0;
      // A mask bit survives only while its request stays high.
      mask_q    <= (mask_q & bus.req) | (tmo_hit ? grant_q : '0);
      timeout_q <= tmo_hit;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign mask        = '0;
  assign bus.timeout = 1'b0;
`endif

  // Eligible secondary requests; the CPU bit never arbitrates.
  logic [N-1:0] pend;
  logic [N-1:0] others;
  assign pend   = bus.req & ~mask & ~CPU_BIT;
  assign others = pend & ~grant_q;

  // Round-robin scan last+1, last+2, ... wrapping from N-1 back to 1.
  logic [MSEL_W-1:0] win;
  logic              win_vld;
  always_comb begin
    int k;
    k       = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int off = 1; off < N; off++) begin
      k = int'(last_q) + off;
      if (k > N - 1) k = k - (N - 1);
      if (!win_vld && pend[MSEL_W'(k)]) begin
        win     = MSEL_W'(k);
        win_vld = 1'b1;
      end
    end
  end

  logic [N-1:0] win_oh;
  assign win_oh = CPU_BIT << win;

  logic drop;
  assign drop = !bus.req[msel_q] || tmo_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= CPU_OWN;
      grant_q   <= CPU_BIT;
      msel_q    <= '0;
      last_q    <= '0;
      busreqn_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        CPU_OWN: if (|pend) begin
          state_q   <= REQ_CPU;
          busreqn_q <= 1'b0;
          busy_q    <= 1'b1;
        end
        REQ_CPU: if (!(|pend)) begin
          state_q   <= RELEASE;
          grant_q   <= '0;
          msel_q    <= '0;
          busreqn_q <= 1'b1;
        end else if (!bus.busackn) begin
          state_q <= GRANT;
          grant_q <= win_oh;
          msel_q  <= win;
          last_q  <= win;
        end
        GRANT: if (drop) begin
          grant_q <= '0;
          if (|others) begin
            state_q <= TURN;           // msel held through the idle cycle
          end else begin
            state_q   <= RELEASE;
            msel_q    <= '0;
            busreqn_q <= 1'b1;
          end
        end
        TURN: if (win_vld) begin
          state_q <= GRANT;
          grant_q <= win_oh;
          msel_q  <= win;
          last_q  <= win;
        end else begin
          state_q   <= RELEASE;
          msel_q    <= '0;
          busreqn_q <= 1'b1;
        end
        RELEASE: if (bus.busackn) begin
          state_q <= CPU_OWN;
          grant_q <= CPU_BIT;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= CPU_OWN;
          grant_q   <= CPU_BIT;
          msel_q    <= '0;
          busreqn_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_q;
  assign bus.msel    = msel_q;
  assign bus.busreqn = busreqn_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_z80_bus_arbiter.sv
module tb_z80_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];   // expected owner index of each secondary grant, in order

  z80_bus_arbiter_if #(.MASTER_QTY(3)) bus();

  z80_bus_arbiter #(.MASTER_QTY(3), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Scoreboard: each new secondary grant is popped against the queued owner.
  logic [2:0] prev_grant = 3'b001;
  always @(negedge clk) begin
    if (reset) begin
      prev_grant = 3'b001;
    end else begin
      if (bus.grant !== prev_grant && bus.grant !== 3'b001 && bus.grant !== 3'b000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got grant %b want none", bus.grant);
        end else begin
          int w;
          w = exp_q.pop_front();
          if (bus.grant !== 3'(1 << w) || bus.msel !== 2'(w)) begin
            errors++;
            $display("FAIL sb_grant: got grant %b msel %0d want owner %0d", bus.grant, bus.msel, w);
          end
        end
      end
      prev_grant = bus.grant;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.busackn = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req = '0;
    bus.busackn = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_grant", 8'(bus.grant), 8'h01);
    chk("rst_msel", 8'(bus.msel), 8'h00);
    chk("rst_busreqn", 8'(bus.busreqn), 8'h01);
    chk("rst_busy", 8'(bus.busy), 8'h00);
    chk("rst_timeout", 8'(bus.timeout), 8'h00);
    tick();
    reset = 1'b0;
    tick();
    // Idle with only the CPU bit set: nothing happens.
    bus.req = 3'b001;
    tick(); tick();
    chk("cpu_req_ignored", 8'({bus.grant, bus.busreqn, bus.busy}), 8'b0011_0);
    bus.req = '0;
  endtask

  task automatic test_single_dma();
    do_reset();
    bus.req = 3'b010;
    tick();
    chk("dma_busreqn", 8'(bus.busreqn), 8'h00);
    chk("dma_req_grant", 8'(bus.grant), 8'h01);
    chk("dma_busy", 8'(bus.busy), 8'h01);
    tick();
    bus.busackn = 1'b0;
    exp_q.push_back(1);
    tick();
    chk("dma_grant", 8'(bus.grant), 8'h02);
    chk("dma_msel", 8'(bus.msel), 8'h01);
    tick();
    bus.req = 3'b000;
    tick();
    chk("dma_rel_grant", 8'(bus.grant), 8'h00);
    chk("dma_rel_busreqn", 8'(bus.busreqn), 8'h01);
    chk("dma_rel_msel", 8'(bus.msel), 8'h00);
    tick();
    chk("dma_rel_wait", 8'(bus.grant), 8'h00);
    bus.busackn = 1'b1;
    tick();
    chk("dma_cpu_back", 8'(bus.grant), 8'h01);
    chk("dma_busy_off", 8'(bus.busy), 8'h00);
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 3'b110;
    tick();
    bus.busackn = 1'b0;
    exp_q.push_back(1);
    tick();
    chk("rr_first", 8'(bus.grant), 8'h02);
    bus.req = 3'b100;
    exp_q.push_back(2);
    tick();
    chk("rr_turn_grant", 8'(bus.grant), 8'h00);
    chk("rr_turn_msel", 8'(bus.msel), 8'h01);
    chk("rr_turn_busreqn", 8'(bus.busreqn), 8'h00);
    tick();
    chk("rr_second", 8'(bus.grant), 8'h04);
    chk("rr_second_msel", 8'(bus.msel), 8'h02);
    bus.req = 3'b010;
    exp_q.push_back(1);
    tick();
    chk("rr_turn2_grant", 8'(bus.grant), 8'h00);
    chk("rr_turn2_msel", 8'(bus.msel), 8'h02);
    tick();
    chk("rr_third", 8'(bus.grant), 8'h02);
    chk("rr_timeout_quiet", 8'(bus.timeout), 8'h00);
    bus.req = 3'b000;
    tick();
    bus.busackn = 1'b1;
    tick();
    chk("rr_cpu_back", 8'(bus.grant), 8'h01);
  endtask

  task automatic test_stalled_cpu();
    int bad;
    do_reset();
    bad = 0;
    bus.req = 3'b010;
    repeat (50) begin
      tick();
      if (bus.grant !== 3'b001 || bus.busreqn !== 1'b0) bad++;
    end
    chk("stall_held", 8'(bad), 8'h00);
    bus.req = 3'b000;
    tick();
    chk("stall_release", 8'({bus.grant, bus.busreqn}), 8'b0000_1);
    tick();
    chk("stall_cpu_back", 8'(bus.grant), 8'h01);
  endtask

  task automatic test_request_during_release();
    do_reset();
    bus.req = 3'b010;
    tick();
    bus.busackn = 1'b0;
    exp_q.push_back(1);
    tick();
    bus.req = 3'b000;
    tick();
    chk("rdr_release", 8'(bus.busreqn), 8'h01);
    bus.req = 3'b100;
    tick(); tick();
    chk("rdr_no_grant", 8'({bus.grant, bus.busreqn}), 8'b0000_1);
    bus.busackn = 1'b1;
    tick();
    chk("rdr_cpu_own", 8'({bus.grant, bus.busy}), 8'b0001_0);
    tick();
    chk("rdr_req_cpu", 8'(bus.busreqn), 8'h00);
    bus.busackn = 1'b0;
    exp_q.push_back(2);
    tick();
    chk("rdr_grant2", 8'(bus.grant), 8'h04);
    bus.req = 3'b000;
    tick();
    bus.busackn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 3'b010;
    tick();
    bus.busackn = 1'b0;
    exp_q.push_back(1);
    tick();
    tick();
    chk("rmg_pre", 8'(bus.grant), 8'h02);
    #2 reset = 1'b1;
    #1;
    chk("rmg_grant", 8'(bus.grant), 8'h01);
    chk("rmg_msel", 8'(bus.msel), 8'h00);
    chk("rmg_busreqn", 8'(bus.busreqn), 8'h01);
    bus.req = 3'b000;
    bus.busackn = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef Z80_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int pulses;
    int bad;
    do_reset();
    bus.req = 3'b010;
    tick();
    bus.busackn = 1'b0;
    exp_q.push_back(1);
    tick();
    n = 0;
    pulses = 0;
    repeat (10) begin
      if (bus.grant === 3'b010) n++;
      if (bus.timeout === 1'b1) begin
        pulses++;
        chk("to_grant_zero", 8'(bus.grant), 8'h00);
      end
      tick();
    end
    chk("to_tenure", 8'(n), 8'h04);
    chk("to_pulses", 8'(pulses), 8'h01);
    bus.busackn = 1'b1;
    tick();
    bad = 0;
    repeat (5) begin
      tick();
      if (bus.grant !== 3'b001 || bus.busreqn !== 1'b1) bad++;
    end
    chk("to_masked", 8'(bad), 8'h00);
    bus.req = 3'b000;
    tick();
    bus.req = 3'b010;
    tick();
    bus.busackn = 1'b0;
    exp_q.push_back(1);
    tick();
    chk("to_regrant", 8'(bus.grant), 8'h02);
    bus.req = 3'b000;
    tick();
    bus.busackn = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_dma();
    test_round_robin();
    test_stalled_cpu();
    test_request_during_release();
    test_reset_mid_grant();
`ifdef Z80_ARB_TIMEOUT_EN
    test_timeout();
`endif
    tick();
    chk("sb_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
